// File: rtl/mouse_position_tracker_pkg.sv
// Shared types and constants for the mouse position tracker.
// Status byte layout, delta/position widths and the delta formation helper.
package mouse_pkg;

  localparam int BIT_L   = 0;
  localparam int BIT_R   = 1;
  localparam int BIT_M   = 2;
  localparam int BIT_ONE = 3;
  localparam int BIT_XS  = 4;
  localparam int BIT_YS  = 5;
  localparam int BIT_XO  = 6;
  localparam int BIT_YO  = 7;

  localparam int DELTA_W = 10;
  localparam int POS_W   = 10;
  localparam int SUM_W   = 12;

  typedef struct packed {
    logic yo;
    logic xo;
    logic ys;
    logic xs;
    logic one;
    logic m;
    logic r;
    logic l;
  } mouse_status_t;

  typedef logic signed [DELTA_W-1:0] delta_t;

  // Overflowed packets carry a meaningless magnitude, so they pin to the extreme.
  function automatic delta_t form_delta(input logic sign, input logic ovf,
                                        input logic [7:0] mag, input logic invert);
    delta_t d;
    if (ovf) begin
      d = sign ? 10'sh300 : 10'sh0FF;
    end else begin
      d = {sign, sign, mag};
    end
    if (invert) begin
      d = -d;
    end
    return d;
  endfunction

endpackage

// File: rtl/mouse_position_tracker_if.sv
// Packet bus from the PS/2 transceiver: one-cycle valid with status and deltas.
// No backpressure; the consumer must accept one packet every cycle.
interface mouse_pkt_if;
  import mouse_pkg::*;

  logic          packet_valid;
  mouse_status_t mouse_status;
  logic [7:0]    mouse_dx;
  logic [7:0]    mouse_dy;

  modport master (
    output packet_valid,
    output mouse_status,
    output mouse_dx,
    output mouse_dy
  );

  modport slave (
    input packet_valid,
    input mouse_status,
    input mouse_dx,
    input mouse_dy
  );

endinterface

// File: rtl/mouse_position_tracker_axis_accum.sv
// One axis: registers the signed delta, then adds it to the position with clamping.
// Latency 2 cycles (delta reg, position reg); no backpressure, one delta per cycle.
module axis_accum
  import mouse_pkg::*;
#(
  parameter int LIMIT  = 160,
  parameter int INIT   = 80,
  parameter bit INVERT = 1'b0
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             accept,
  input  logic             sign,
  input  logic             ovf,
  input  logic [7:0]       mag,
  input  logic             apply,
  input  logic             recentre,
  output logic [POS_W-1:0] pos
);

  localparam logic [POS_W-1:0]        INIT_POS = POS_W'(INIT);
  localparam logic [POS_W-1:0]        MAX_POS  = POS_W'(LIMIT - 1);
  localparam logic signed [SUM_W-1:0] MAX_SUM  = SUM_W'(LIMIT - 1);

  delta_t                  s1_delta;
  logic signed [SUM_W-1:0] sum;
  logic [POS_W-1:0]        clamped;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      s1_delta <= '0;
    end else if (accept) begin
      s1_delta <= form_delta(sign, ovf, mag, INVERT);
    end
  end

  // Position is always non-negative, so zero-extend it; the delta sign-extends.
  always_comb begin
    sum = $signed({{(SUM_W-POS_W){1'b0}}, pos})
        + $signed({{(SUM_W-DELTA_W){s1_delta[DELTA_W-1]}}, s1_delta});
    if (sum < 0) begin
      clamped = '0;
    end else if (sum > MAX_SUM) begin
      clamped = MAX_POS;
    end else begin
      clamped = sum[POS_W-1:0];
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      pos <= INIT_POS;
    end else if (recentre) begin
      pos <= INIT_POS;
    end else if (apply) begin
      pos <= clamped;
    end
  end

endmodule

// File: rtl/mouse_position_tracker.sv
// Turns PS/2 relative packets into clamped absolute X/Y plus buttons and click pulses.
// Latency 2 cycles packet_valid -> pos_valid; no backpressure, one packet per cycle.
module mouse_position_tracker
  import mouse_pkg::*;
#(
  parameter int X_LIMIT  = 160,
  parameter int Y_LIMIT  = 120,
  parameter int X_INIT   = 80,
  parameter int Y_INIT   = 60,
  parameter bit Y_INVERT = 1'b1
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  mouse_pkt_if.slave       pkt,
  input  logic             recentre,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic [2:0]       buttons,
  output logic             click_l,
  output logic             click_r,
  output logic             pos_valid,
  output logic [7:0]       err_cnt
);

  logic       accept;
  logic       bad_frame;
  logic       s1_vld;
  logic [2:0] s1_btn;

  // Bit 3 of a genuine status byte is always set; anything else is a framing slip.
  assign accept    = pkt.packet_valid &  pkt.mouse_status.one;
  assign bad_frame = pkt.packet_valid & ~pkt.mouse_status.one;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_btn <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_btn <= {pkt.mouse_status.m, pkt.mouse_status.r, pkt.mouse_status.l};
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (bad_frame && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      buttons   <= '0;
      click_l   <= 1'b0;
      click_r   <= 1'b0;
      pos_valid <= 1'b0;
    end else begin
      pos_valid <= s1_vld | recentre;
      click_l   <= s1_vld & s1_btn[BIT_L] & ~buttons[BIT_L];
      click_r   <= s1_vld & s1_btn[BIT_R] & ~buttons[BIT_R];
      if (s1_vld) begin
        buttons <= s1_btn;
      end
    end
  end

  axis_accum #(
    .LIMIT  (X_LIMIT),
    .INIT   (X_INIT),
    .INVERT (1'b0)
  ) u_axis_x (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .accept   (accept),
    .sign     (pkt.mouse_status.xs),
    .ovf      (pkt.mouse_status.xo),
    .mag      (pkt.mouse_dx),
    .apply    (s1_vld),
    .recentre (recentre),
    .pos      (pos_x)
  );

  axis_accum #(
    .LIMIT  (Y_LIMIT),
    .INIT   (Y_INIT),
    .INVERT (Y_INVERT)
  ) u_axis_y (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .accept   (accept),
    .sign     (pkt.mouse_status.ys),
    .ovf      (pkt.mouse_status.yo),
    .mag      (pkt.mouse_dy),
    .apply    (s1_vld),
    .recentre (recentre),
    .pos      (pos_y)
  );

endmodule
